// File: rtl/lifo_burst_reader_if.sv
// Output word stream of the LIFO burst reader: valid/ready handshake with a last-word marker.
`timescale 1ns/1ps
interface lifo_burst_reader_if #(
  parameter int DATA_W = 32
);
  logic              valid;
  logic [DATA_W-1:0] data;
  logic              last;
  logic              ready;

  modport master (output valid, output data, output last, input ready);
  modport slave  (input valid, input data, input last, output ready);
endinterface

// File: rtl/lifo_burst_reader.sv
// Pops a burst from an FWFT LIFO (newest first) and streams it out through a 2-entry skid buffer.
// State table:  IDLE | waiting for start    POP | issuing pops   FLUSH | draining buffer   DONE | one-cycle done pulse
`timescale 1ns/1ps
module lifo_burst_reader #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              abort,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic              lifo_r_req,
  input  logic [DATA_W-1:0] lifo_r_data,
  input  logic              lifo_empty,
  input  logic [CNT_W-1:0]  lifo_cnt,
  lifo_burst_reader_if.master m
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_POP   = 2'd1;
  localparam logic [1:0] S_FLUSH = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_words_left;
  logic              r_aborted;
  logic [1:0]        r_buf_cnt;
  logic [DATA_W-1:0] r_head_data;
  logic              r_head_last;
  logic [DATA_W-1:0] r_tail_data;
  logic              r_tail_last;

  logic              w_abort;
  logic              w_hs;
  logic              w_push;
  logic              w_push_last;
  logic              w_drained;
  logic [CNT_W-1:0]  w_start_len;

  assign w_abort     = abort && ((r_state == S_POP) || (r_state == S_FLUSH));
  assign w_hs        = (r_buf_cnt != 2'd0) && m.ready;
  // Pop decision uses only registered state and lifo_empty; abort merely vetoes it.
  assign w_push      = (r_state == S_POP) && !lifo_empty && (r_buf_cnt < 2'd2) &&
                       (r_words_left != '0) && !abort;
  assign w_push_last = (r_words_left == CNT_W'(1));
  assign w_drained   = (r_buf_cnt == 2'd0) || ((r_buf_cnt == 2'd1) && w_hs);
  assign w_start_len = ((len == '0) || (len > lifo_cnt)) ? lifo_cnt : len;

  assign lifo_r_req = w_push;
  assign busy       = (r_state != S_IDLE);
  assign done       = (r_state == S_DONE);
  assign aborted    = r_aborted;
  assign m.valid    = (r_buf_cnt != 2'd0);
  assign m.data     = r_head_data;
  assign m.last     = r_head_last;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_words_left <= '0;
      r_aborted    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_words_left <= w_start_len;
            r_state      <= (w_start_len == '0) ? S_DONE : S_POP;
          end
        end
        S_POP: begin
          if (w_abort) begin
            r_words_left <= '0;
            r_aborted    <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_push) begin
            r_words_left <= r_words_left - CNT_W'(1);
            if (w_push_last) r_state <= S_FLUSH;
          end
        end
        S_FLUSH: begin
          if (w_abort) begin
            r_words_left <= '0;
            r_aborted    <= 1'b1;
            r_state      <= S_DONE;
          end else if (w_drained) begin
            r_state <= S_DONE;
          end
        end
        default: begin
          r_aborted <= 1'b0;
          r_state   <= S_IDLE;
        end
      endcase
    end
  end

  // Head register only reloads on a push or when the tail moves up, so m.data holds while empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_buf_cnt   <= 2'd0;
      r_head_data <= '0;
      r_head_last <= 1'b0;
      r_tail_data <= '0;
      r_tail_last <= 1'b0;
    end else if (w_abort) begin
      r_buf_cnt <= 2'd0;
    end else begin
      case (r_buf_cnt)
        2'd0: begin
          if (w_push) begin
            r_head_data <= lifo_r_data;
            r_head_last <= w_push_last;
            r_buf_cnt   <= 2'd1;
          end
        end
        2'd1: begin
          if (w_push && w_hs) begin
            r_head_data <= lifo_r_data;
            r_head_last <= w_push_last;
          end else if (w_push) begin
            r_tail_data <= lifo_r_data;
            r_tail_last <= w_push_last;
            r_buf_cnt   <= 2'd2;
          end else if (w_hs) begin
            r_buf_cnt <= 2'd0;
          end
        end
        default: begin
          if (w_hs) begin
            r_head_data <= r_tail_data;
            r_head_last <= r_tail_last;
            r_buf_cnt   <= 2'd1;
          end
        end
      endcase
    end
  end

endmodule
